// File: rtl/hpd_edid_ctl_if.sv
// Hot-plug / EDID handshake bundle between the HPD sequencer and its surroundings.
interface hpd_edid_ctl_if;
  logic       sink_hpd;
  logic       edid_ok;
  logic       edid_init;
  logic       src_hpd;
  logic       edid_fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  // Sequencer side
  modport master (
    input  sink_hpd, edid_ok,
    output edid_init, src_hpd, edid_fail, retry_cnt, state_dbg
  );

  // Monitor / EDID copy stage / video source side
  modport slave (
    output sink_hpd, edid_ok,
    input  edid_init, src_hpd, edid_fail, retry_cnt, state_dbg
  );
endinterface

// File: rtl/hpd_edid_ctl.sv
// Hot-plug sequencer: debounces sink HPD, requests an EDID copy, and raises
// source HPD only after a good copy plus a settle delay. Retries on timeout.
module hpd_edid_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 250000,
  parameter int unsigned HPD_DELAY_CYCLES = 2500000,
  parameter int unsigned TIMEOUT_CYCLES   = 25000000,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned CNT_W            = 25
) (
  input  logic           gclk,
  input  logic           rst,
  hpd_edid_ctl_if.master bus
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HD_LAST  = CNT_W'(HPD_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DELAY  = 3'd3,
    ACTIVE = 3'd4,
    FAIL   = 3'd5
  } state_t;

  logic             hpd_m, hpd_s;
  logic             hpd_db;
  logic [CNT_W-1:0] db_cnt;
  logic             edid_ok_q;
  logic             ok_rise;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       retry, retry_n;
  logic             edid_init_q, src_hpd_q, edid_fail_q;

  // Two-flop synchronizer for the asynchronous monitor HPD
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      hpd_m <= 1'b0;
      hpd_s <= 1'b0;
    end else begin
      hpd_m <= bus.sink_hpd;
      hpd_s <= hpd_m;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      db_cnt <= '0;
      hpd_db <= 1'b0;
    end else if (hpd_s == hpd_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      hpd_db <= hpd_s;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Previous edid_ok so that only a fresh rising edge counts as completion
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) edid_ok_q <= 1'b0;
    else      edid_ok_q <= bus.edid_ok;
  end

  assign ok_rise = bus.edid_ok & ~edid_ok_q;

  // State, shared counter and registered outputs
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      retry       <= '0;
      edid_init_q <= 1'b0;
      src_hpd_q   <= 1'b0;
      edid_fail_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry       <= retry_n;
      edid_init_q <= (state_n == REQ);
      src_hpd_q   <= (state_n == ACTIVE);
      edid_fail_q <= (state_n == FAIL);
    end
  end

  // Next-state logic; unplug overrides every other transition
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry;

    unique case (state)
      IDLE: begin
        cnt_n   = '0;
        retry_n = '0;
        if (hpd_db) begin
          state_n = REQ;
          retry_n = 2'd1;
        end
      end
      REQ: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (ok_rise) begin
          state_n = DELAY;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          cnt_n = '0;
          if (retry < RETRY_MX) begin
            state_n = REQ;
            retry_n = retry + 2'd1;
          end else begin
            state_n = FAIL;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DELAY: begin
        if (cnt == HD_LAST) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ACTIVE, FAIL: begin
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        retry_n = '0;
      end
    endcase

    if (state != IDLE && !hpd_db) begin
      state_n = IDLE;
      cnt_n   = '0;
      retry_n = '0;
    end
  end

  assign bus.edid_init = edid_init_q;
  assign bus.src_hpd   = src_hpd_q;
  assign bus.edid_fail = edid_fail_q;
  assign bus.retry_cnt = retry;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_hpd_edid_ctl.sv
// Bench for hpd_edid_ctl: event times predicted from the timing rules.
module tb_hpd_edid_ctl;

  localparam int DB = 4;
  localparam int HD = 8;
  localparam int TO = 50;
  localparam int MR = 2;

  logic gclk = 1'b0;
  logic rst  = 1'b0;

  hpd_edid_ctl_if bus ();

  hpd_edid_ctl #(
    .DEBOUNCE_CYCLES (DB),
    .HPD_DELAY_CYCLES(HD),
    .TIMEOUT_CYCLES  (TO),
    .MAX_RETRY       (MR),
    .CNT_W           (25)
  ) dut (
    .gclk(gclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 gclk = ~gclk;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  // Rising-edge count; value at a sample point names the last edge
  always @(posedge gclk) cyc <= cyc + 1;

  // Event log: cycles where edid_init is seen high and where src_hpd rises
  int   init_q[$];
  int   rise_q[$];
  logic init_prev = 1'b0;
  logic src_prev  = 1'b0;
  int   dbl_init  = 0;
  always @(negedge gclk) begin
    if (bus.edid_init) begin
      init_q.push_back(cyc);
      if (init_prev) dbl_init++;
    end
    init_prev = bus.edid_init;
    if (bus.src_hpd && !src_prev) rise_q.push_back(cyc);
    src_prev = bus.src_hpd;
  end

  // Reference model: timing rules as plain arithmetic
  function automatic int exp_init(input int plug_cyc);
    return plug_cyc + 2 + DB + 1;
  endfunction
  function automatic int exp_rise(input int ok_cyc);
    return ok_cyc + 1 + HD;
  endfunction
  function automatic int exp_retry(input int prev_init);
    return prev_init + 1 + TO;
  endfunction
  function automatic int exp_idle(input int unplug_cyc);
    return unplug_cyc + 2 + DB + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic clear_log();
    init_q.delete();
    rise_q.delete();
  endtask

  task automatic settle_unplugged();
    bus.sink_hpd = 1'b0;
    bus.edid_ok  = 1'b0;
    tick(2 + DB + 4);
    clear_log();
  endtask

  // Plug and wait for the first request; returns its cycle (or -1)
  task automatic plug(output int p, output int i0);
    p = cyc;
    bus.sink_hpd = 1'b1;
    for (int k = 0; k < 20 && init_q.size() == 0; k++) tick(1);
    i0 = (init_q.size() > 0) ? init_q[0] : -1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int seen);
    seen = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge gclk);
      if (bus.state_dbg == s) begin seen = cyc; break; end
    end
    tick(1);
  endtask

  task automatic test_reset();
    bus.sink_hpd = 1'b0;
    bus.edid_ok  = 1'b0;
    rst = 1'b0;
    tick(3);
    vec++;
    if ({bus.edid_init, bus.src_hpd, bus.edid_fail, bus.retry_cnt} !== 5'b0) begin
      err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus.edid_init, bus.src_hpd, bus.edid_fail, bus.retry_cnt});
    end
    vec++;
    if (bus.state_dbg !== 3'd0) begin
      err++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg);
    end
    rst = 1'b1;
    tick(2);
    clear_log();
  endtask

  task automatic test_good_read();
    int p, i0, d, o;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 20 : int'($urandom_range(2, 40));
      plug(p, i0);
      vec++;
      if (i0 != exp_init(p)) begin
        err++; $display("FAIL good_init_lat: got %0d expected %0d", i0, exp_init(p));
      end
      wait_until(i0 + d);
      bus.edid_ok = 1'b1;
      o = cyc;
      for (int k = 0; k < 20 && rise_q.size() == 0; k++) tick(1);
      vec++;
      if (rise_q.size() != 1 || rise_q[0] != exp_rise(o)) begin
        err++;
        $display("FAIL good_src_rise: got %0d (n=%0d) expected %0d",
                 (rise_q.size() > 0) ? rise_q[0] : -1, rise_q.size(), exp_rise(o));
      end
      vec++;
      if (bus.retry_cnt !== 2'd1 || bus.state_dbg !== 3'd4 || init_q.size() != 1) begin
        err++;
        $display("FAIL good_final: retry=%0d state=%0d inits=%0d expected 1/4/1",
                 bus.retry_cnt, bus.state_dbg, init_q.size());
      end
      settle_unplugged();
    end
  endtask

  task automatic test_glitch();
    int p, i0, len;
    for (int it = 0; it < 4; it++) begin
      len = (it == 0) ? DB - 1 : int'($urandom_range(1, DB - 1));
      bus.sink_hpd = 1'b1;
      tick(len);
      bus.sink_hpd = 1'b0;
      tick(12);
      vec++;
      if (init_q.size() != 0 || bus.state_dbg !== 3'd0 || dut.hpd_db !== 1'b0) begin
        err++;
        $display("FAIL glitch_high_len%0d: inits=%0d state=%0d hpd_db=%b expected 0/0/0",
                 len, init_q.size(), bus.state_dbg, dut.hpd_db);
      end
    end
    plug(p, i0);
    tick(3);
    bus.edid_ok = 1'b1;
    tick(HD + 4);
    for (int it = 0; it < 3; it++) begin
      len = (it == 0) ? DB - 1 : int'($urandom_range(1, DB - 1));
      bus.sink_hpd = 1'b0;
      tick(len);
      bus.sink_hpd = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge gclk);
        vec++;
        if (bus.src_hpd !== 1'b1 || bus.state_dbg !== 3'd4) begin
          err++;
          $display("FAIL glitch_low_len%0d: src_hpd=%b state=%0d expected 1/4",
                   len, bus.src_hpd, bus.state_dbg);
        end
      end
      tick(1);
    end
    settle_unplugged();
  endtask

  task automatic test_timeout_retry(input logic stale);
    int p, i0, fc, u, last;
    bus.edid_ok = stale;
    tick(2);
    plug(p, i0);
    wait_state(3'd5, 3 * (TO + 5), fc);
    vec++;
    if (init_q.size() != MR) begin
      err++; $display("FAIL to_init_count(stale=%b): got %0d expected %0d", stale, init_q.size(), MR);
    end else begin
      vec++;
      if (init_q[0] != exp_init(p) || init_q[1] != exp_retry(init_q[0])) begin
        err++;
        $display("FAIL to_init_times(stale=%b): got %0d,%0d expected %0d,%0d",
                 stale, init_q[0], init_q[1], exp_init(p), exp_retry(exp_init(p)));
      end
      last = init_q[MR - 1];
      vec++;
      if (fc != exp_retry(last)) begin
        err++; $display("FAIL to_fail_time(stale=%b): got %0d expected %0d", stale, fc, exp_retry(last));
      end
    end
    vec++;
    if (bus.edid_fail !== 1'b1 || bus.retry_cnt !== 2'(MR) || bus.src_hpd !== 1'b0) begin
      err++;
      $display("FAIL to_fail_outputs: fail=%b retry=%0d src=%b expected 1/%0d/0",
               bus.edid_fail, bus.retry_cnt, bus.src_hpd, MR);
    end
    bus.sink_hpd = 1'b0;
    u = cyc;
    wait_until(exp_idle(u) - 1);
    @(negedge gclk);
    vec++;
    if (bus.state_dbg !== 3'd5 || bus.edid_fail !== 1'b1) begin
      err++; $display("FAIL to_unplug_early: state=%0d fail=%b expected 5/1", bus.state_dbg, bus.edid_fail);
    end
    tick(1);
    @(negedge gclk);
    vec++;
    if (bus.state_dbg !== 3'd0 || bus.edid_fail !== 1'b0 || bus.retry_cnt !== 2'd0) begin
      err++;
      $display("FAIL to_unplug_idle: state=%0d fail=%b retry=%0d expected 0/0/0",
               bus.state_dbg, bus.edid_fail, bus.retry_cnt);
    end
    tick(1);
    settle_unplugged();
  endtask

  task automatic test_stale_then_toggle();
    int p, i0, o;
    bus.edid_ok = 1'b1;
    tick(2);
    plug(p, i0);
    wait_until(i0 + 2);
    bus.edid_ok = 1'b0;
    wait_until(i0 + 6);
    bus.edid_ok = 1'b1;
    o = cyc;
    for (int k = 0; k < 20 && rise_q.size() == 0; k++) tick(1);
    vec++;
    if (rise_q.size() != 1 || rise_q[0] != exp_rise(o) || init_q.size() != 1) begin
      err++;
      $display("FAIL toggle_ok_rise: got %0d (inits=%0d) expected %0d",
               (rise_q.size() > 0) ? rise_q[0] : -1, init_q.size(), exp_rise(o));
    end
    settle_unplugged();
  endtask

  task automatic test_unplug_delay();
    int p, i0, o, dstart, k, u, idle_seen, p2, i2;
    for (int it = 0; it < 2; it++) begin
      k = it;
      plug(p, i0);
      wait_until(i0 + int'($urandom_range(2, 30)));
      bus.edid_ok = 1'b1;
      o = cyc;
      dstart = o + 1;
      wait_until(dstart + k);
      bus.sink_hpd = 1'b0;
      u = cyc;
      wait_state(3'd0, 20, idle_seen);
      vec++;
      if (idle_seen != exp_idle(u)) begin
        err++; $display("FAIL unplug_delay_idle_k%0d: got %0d expected %0d", k, idle_seen, exp_idle(u));
      end
      tick(HD);
      vec++;
      if (rise_q.size() != 0) begin
        err++; $display("FAIL unplug_delay_src_k%0d: got %0d rises expected 0", k, rise_q.size());
      end
      bus.edid_ok = 1'b0;
      tick(2);
      clear_log();
      plug(p2, i2);
      @(negedge gclk);
      vec++;
      if (i2 != exp_init(p2) || bus.retry_cnt !== 2'd1) begin
        err++;
        $display("FAIL replug_k%0d: init=%0d retry=%0d expected %0d/1", k, i2, bus.retry_cnt, exp_init(p2));
      end
      tick(1);
      settle_unplugged();
    end
  endtask

  task automatic test_async_reset();
    int p, i0, r, i2;
    plug(p, i0);
    tick(3);
    bus.edid_ok = 1'b1;
    tick(HD + 4);
    #1 rst = 1'b0;
    #1;
    vec++;
    if (bus.src_hpd !== 1'b0 || bus.state_dbg !== 3'd0 || bus.edid_init !== 1'b0) begin
      err++;
      $display("FAIL async_reset: src=%b state=%0d init=%b expected 0/0/0",
               bus.src_hpd, bus.state_dbg, bus.edid_init);
    end
    bus.edid_ok = 1'b0;
    tick(3);
    clear_log();
    rst = 1'b1;
    r = cyc;
    for (int k = 0; k < 20 && init_q.size() == 0; k++) tick(1);
    i2 = (init_q.size() > 0) ? init_q[0] : -1;
    vec++;
    if (i2 != exp_init(r)) begin
      err++; $display("FAIL reset_restart_init: got %0d expected %0d", i2, exp_init(r));
    end
    settle_unplugged();
  endtask

  task automatic test_no_double_init();
    vec++;
    if (dbl_init != 0) begin
      err++; $display("FAIL init_consecutive: got %0d back-to-back pulses expected 0", dbl_init);
    end
  endtask

  initial begin
    bus.sink_hpd = 1'b0;
    bus.edid_ok  = 1'b0;
    test_reset();
    test_good_read();
    test_glitch();
    test_timeout_retry(1'b0);
    test_timeout_retry(1'b1);
    test_stale_then_toggle();
    test_unplug_delay();
    test_async_reset();
    test_no_double_init();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
